// File: rtl/uart_pkg.sv
// Shared UART definitions: interrupt ID codes, RX trigger-select encodings and
// the per-character receive error flags.
package uart_pkg;

    localparam logic [3:0] IID_NONE = 4'b0001;
    localparam logic [3:0] IID_RLS  = 4'b0110;
    localparam logic [3:0] IID_RDA  = 4'b0100;
    localparam logic [3:0] IID_TO   = 4'b1100;
    localparam logic [3:0] IID_THRE = 4'b0010;

    localparam logic [1:0] TRIG_ONE     = 2'b00;
    localparam logic [1:0] TRIG_QUARTER = 2'b01;
    localparam logic [1:0] TRIG_HALF    = 2'b10;
    localparam logic [1:0] TRIG_NEARFUL = 2'b11;

    // Upper bits of every buffered entry; data sits below these.
    typedef struct packed {
        logic brk;
        logic ferr;
        logic perr;
    } rx_err_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; a write into a full FIFO is accepted
// only when a read pops the head in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             push_c,
    output logic             pop_c,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, full_q;

    // Accept/pop decisions and next pointers; pointers wrap naturally at DEPTH.
    always_comb begin
        pop_c    = rd_en && !empty_q && !clr;
        push_c   = wr_en && (!full_q || pop_c) && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
            else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/uart_rx_buffer_irq.sv
// UART receive buffer with error tracking, trigger/timeout/overrun detection
// and a 16550-style prioritised interrupt ID.
module uart_rx_buffer_irq
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIMEOUT_CHARS = 4,
    localparam int unsigned CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_perr,
    input  logic              rx_ferr,
    input  logic              rx_brk,
    input  logic              char_tick,
    input  logic              rd_en,
    input  logic              lsr_rd,
    input  logic              iir_rd,
    input  logic              fifo_clr,
    input  logic [1:0]        trig_sel,
    input  logic [2:0]        ier,
    input  logic              thr_empty,
    input  logic              thr_wr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rd_brk,
    output logic              data_ready,
    output logic              overrun,
    output logic              fifo_err,
    output logic [CNT_W-1:0]  count,
    output logic [3:0]        iid,
    output logic              irq
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CHARS + 1);

    typedef struct packed {
        rx_err_t           err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           wr_entry, rd_entry;
    logic             push_c, pop_c, empty, full;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fifo_err_q, overrun_q, overrun_d;
    logic             rls_q, rls_d, thre_q, thre_d;
    logic             thr_empty_q, ier1_q;
    logic             err_inc, err_dec, ovr_set, thre_set, thre_clr;
    logic [CNT_W-1:0] trig_lvl;
    logic             rda_pend, to_pend;

    assign wr_entry = {rx_brk, rx_ferr, rx_perr, rx_data};

    uart_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (fifo_clr),
        .wr_en  (rx_valid),
        .wdata  (wr_entry),
        .rd_en  (rd_en),
        .rdata  (rd_entry),
        .push_c (push_c),
        .pop_c  (pop_c),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    // Next state for line-status, error-entry tracking and THR-empty flags.
    always_comb begin
        err_inc   = push_c && (|wr_entry.err);
        err_dec   = pop_c && (|rd_entry.err);
        ovr_set   = rx_valid && full && !rd_en && !fifo_clr;
        thre_set  = (thr_empty && !thr_empty_q) || (ier[1] && !ier1_q && thr_empty);
        thre_clr  = thr_wr || (iir_rd && (iid == IID_THRE));
        overrun_d = ovr_set || (overrun_q && !lsr_rd);
        err_cnt_d = err_cnt_q + CNT_W'(err_inc) - CNT_W'(err_dec);
        rls_d     = ovr_set || err_inc || (rls_q && !lsr_rd);
        thre_d    = thre_set || (thre_q && !thre_clr);
        if (fifo_clr) begin
            err_cnt_d = '0;
            rls_d     = 1'b0;
            thre_d    = 1'b0;
        end
    end

    // Character timeout: idle char times while data sits in the buffer.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rx_valid || rd_en || fifo_clr || (count == '0)) begin
            to_cnt_d = '0;
        end else if (char_tick && (to_cnt_q != TO_W'(TIMEOUT_CHARS))) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            err_cnt_q   <= '0;
            fifo_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            rls_q       <= 1'b0;
            thre_q      <= 1'b0;
            thr_empty_q <= 1'b0;
            ier1_q      <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fifo_err_q  <= (err_cnt_d != '0);
            overrun_q   <= overrun_d;
            rls_q       <= rls_d;
            thre_q      <= thre_d;
            thr_empty_q <= thr_empty;
            ier1_q      <= ier[1];
        end
    end

    always_comb begin
        trig_lvl = CNT_W'(DEPTH - 2);
        case (trig_sel)
            TRIG_ONE:     trig_lvl = CNT_W'(1);
            TRIG_QUARTER: trig_lvl = CNT_W'(DEPTH / 4);
            TRIG_HALF:    trig_lvl = CNT_W'(DEPTH / 2);
            TRIG_NEARFUL: trig_lvl = CNT_W'(DEPTH - 2);
        endcase
    end

    assign rda_pend = ier[0] && (count >= trig_lvl);
    assign to_pend  = ier[0] && (to_cnt_q == TO_W'(TIMEOUT_CHARS)) && (count != '0);

    // Interrupt priority: line status > data available > timeout > THR empty.
    always_comb begin
        iid = IID_NONE;
        if (rls_q && ier[2])       iid = IID_RLS;
        else if (rda_pend)         iid = IID_RDA;
        else if (to_pend)          iid = IID_TO;
        else if (thre_q && ier[1]) iid = IID_THRE;
    end

    assign irq        = ~iid[0];
    assign rd_data    = rd_entry.data;
    assign rd_perr    = rd_entry.err.perr;
    assign rd_ferr    = rd_entry.err.ferr;
    assign rd_brk     = rd_entry.err.brk;
    assign data_ready = ~empty;
    assign overrun    = overrun_q;
    assign fifo_err   = fifo_err_q;

endmodule

// File: tb/tb_uart_rx_buffer_irq.sv
// Scoreboard bench for uart_rx_buffer_irq: accepted characters are queued and
// compared against the show-ahead head whenever a read pops it.
module tb_uart_rx_buffer_irq;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TO_CH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid, rx_perr, rx_ferr, rx_brk;
    logic [DATA_W-1:0] rx_data;
    logic              char_tick, rd_en, lsr_rd, iir_rd, fifo_clr;
    logic [1:0]        trig_sel;
    logic [2:0]        ier;
    logic              thr_empty, thr_wr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr, rd_ferr, rd_brk;
    logic              data_ready, overrun, fifo_err;
    logic [CNT_W-1:0]  count;
    logic [3:0]        iid;
    logic              irq;

    uart_rx_buffer_irq #(
        .DATA_W        (DATA_W),
        .DEPTH         (DEPTH),
        .TIMEOUT_CHARS (TO_CH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr),
        .rx_brk     (rx_brk),
        .char_tick  (char_tick),
        .rd_en      (rd_en),
        .lsr_rd     (lsr_rd),
        .iir_rd     (iir_rd),
        .fifo_clr   (fifo_clr),
        .trig_sel   (trig_sel),
        .ier        (ier),
        .thr_empty  (thr_empty),
        .thr_wr     (thr_wr),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr),
        .rd_ferr    (rd_ferr),
        .rd_brk     (rd_brk),
        .data_ready (data_ready),
        .overrun    (overrun),
        .fifo_err   (fifo_err),
        .count      (count),
        .iid        (iid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    logic        mdl_ovr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle of optional write and/or read, with model update and checks.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] err, input logic r);
        logic popped;
        @(negedge clk);
        popped = r && (exp_q.size() != 0);
        if (popped) check_val("head", 32'({rd_brk, rd_ferr, rd_perr, rd_data}), 32'(exp_q[0]));
        rx_valid = v;
        rx_data  = d;
        {rx_brk, rx_ferr, rx_perr} = err;
        rd_en    = r;
        if (popped) void'(exp_q.pop_front());
        if (v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({err, d});
            else mdl_ovr = 1'b1;
        end
        cyc();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        {rx_brk, rx_ferr, rx_perr} = 3'b000;
        check_val("count", 32'(count), 32'(exp_q.size()));
        check_val("data_ready", 32'(data_ready), 32'(exp_q.size() != 0));
        check_val("overrun", 32'(overrun), 32'(mdl_ovr));
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] err);
        step(1'b1, d, err, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 3'b000, 1'b1);
    endtask

    // 0 char_tick, 1 lsr_rd, 2 iir_rd, 3 thr_wr, 4 fifo_clr
    task automatic strobe(input int sel);
        @(negedge clk);
        case (sel)
            0: char_tick = 1'b1;
            1: begin lsr_rd = 1'b1; mdl_ovr = 1'b0; end
            2: iir_rd = 1'b1;
            3: thr_wr = 1'b1;
            default: begin fifo_clr = 1'b1; exp_q.delete(); end
        endcase
        cyc();
        {char_tick, lsr_rd, iir_rd, thr_wr, fifo_clr} = 5'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {rx_valid, rx_perr, rx_ferr, rx_brk, char_tick, rd_en} = 6'b0;
        {lsr_rd, iir_rd, fifo_clr, thr_empty, thr_wr} = 5'b0;
        rx_data  = '0;
        trig_sel = 2'b00;
        ier      = 3'b001;
        repeat (2) cyc();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_iid", 32'(iid), 32'h1);
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        check_val("rst_fifo_err", 32'(fifo_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single character, trigger level 1
        push(8'h41, 3'b000);
        check_val("t1_rd_data", 32'(rd_data), 32'h41);
        check_val("t1_iid", 32'(iid), 32'h4);
        check_val("t1_irq", 32'(irq), 32'd1);
        pop();
        check_val("t1_iid_empty", 32'(iid), 32'h1);

        // Half-full trigger
        trig_sel = 2'b10;
        for (int i = 0; i < 7; i++) push(8'(8'h20 + i), 3'b000);
        check_val("t2_iid_7", 32'(iid), 32'h1);
        push(8'h27, 3'b000);
        check_val("t2_iid_8", 32'(iid), 32'h4);
        pop();
        check_val("t2_iid_pop", 32'(iid), 32'h1);
        strobe(4);
        check_val("t2_clr_count", 32'(count), 32'd0);

        // Character timeout
        push(8'h30, 3'b000);
        push(8'h31, 3'b000);
        for (int i = 0; i < 3; i++) strobe(0);
        check_val("t3_iid_3tick", 32'(iid), 32'h1);
        strobe(0);
        check_val("t3_iid_to", 32'(iid), 32'hC);
        pop();
        check_val("t3_iid_after_rd", 32'(iid), 32'h1);
        for (int i = 0; i < 3; i++) strobe(0);
        check_val("t3_iid_3tick_b", 32'(iid), 32'h1);
        strobe(0);
        check_val("t3_iid_to_b", 32'(iid), 32'hC);
        pop();
        check_val("t3_iid_empty", 32'(iid), 32'h1);

        // Overrun, line-status priority, full + simultaneous read/write, wrap
        trig_sel = 2'b00;
        ier      = 3'b101;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i), 3'b000);
        push(8'h55, 3'b000);
        check_val("t4_iid_rls", 32'(iid), 32'h6);
        strobe(1);
        check_val("t4_ovr_clr", 32'(overrun), 32'd0);
        check_val("t4_iid_rda", 32'(iid), 32'h4);
        step(1'b1, 8'h66, 3'b000, 1'b1);
        for (int i = 0; i < 16; i++) pop();

        // Per-entry errors and fifo_err
        ier = 3'b001;
        push(8'h10, 3'b001);
        push(8'h11, 3'b000);
        check_val("t5_fifo_err", 32'(fifo_err), 32'd1);
        check_val("t5_rd_perr", 32'(rd_perr), 32'd1);
        ier = 3'b101;
        #1 check_val("t5_iid_rls", 32'(iid), 32'h6);
        strobe(1);
        check_val("t5_iid_rls_clr", 32'(iid), 32'h4);
        ier = 3'b001;
        pop();
        check_val("t5_fifo_err_pop", 32'(fifo_err), 32'd0);
        check_val("t5_rd_data", 32'(rd_data), 32'h11);
        check_val("t5_rd_perr_pop", 32'(rd_perr), 32'd0);
        pop();
        push(8'h12, 3'b100);
        check_val("t5_rd_brk", 32'(rd_brk), 32'd1);
        check_val("t5_fifo_err_brk", 32'(fifo_err), 32'd1);
        pop();
        check_val("t5_fifo_err_end", 32'(fifo_err), 32'd0);
        strobe(1);
        step(1'b1, 8'h77, 3'b000, 1'b1);
        pop();

        // THR-empty interrupt
        ier = 3'b010;
        cyc();
        check_val("t6_iid_idle", 32'(iid), 32'h1);
        thr_empty = 1'b1;
        cyc();
        check_val("t6_iid_thre", 32'(iid), 32'h2);
        check_val("t6_irq", 32'(irq), 32'd1);
        strobe(2);
        check_val("t6_iid_iir_rd", 32'(iid), 32'h1);
        thr_empty = 1'b0;
        cyc();
        thr_empty = 1'b1;
        cyc();
        check_val("t6_iid_thre_b", 32'(iid), 32'h2);
        strobe(3);
        check_val("t6_iid_thr_wr", 32'(iid), 32'h1);
        ier = 3'b000;
        cyc();
        ier = 3'b010;
        cyc();
        check_val("t6_iid_ier_rise", 32'(iid), 32'h2);
        strobe(3);
        thr_empty = 1'b0;
        ier = 3'b001;

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 3'b000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_count", 32'(count), 32'd0);
        check_val("arst_iid", 32'(iid), 32'h1);
        check_val("arst_drdy", 32'(data_ready), 32'd0);
        exp_q.delete();
        mdl_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
